mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/rv_pkg.sv | 40 ++++
 rtl/lsu_align.sv | 62 ++++++
 rtl/mem_stage.sv | 215 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg -- shared definitions for the memory stage.
//   * mem2reg writeback-select encodings
//   * funct3 access size / sign encodings
//   * memory-stage FSM state type
//   * is_misaligned(): natural-alignment check used when the optional
//     misalignment trap (macro MEM_MISALIGN_TRAP_EN) is built in
// ---------------------------------------------------------------------------
package rv_pkg;

  // Writeback source select carried through MEM/WB.
  localparam logic [1:0] M2R_NPC = 2'b00;
  localparam logic [1:0] M2R_ALU = 2'b01;
  localparam logic [1:0] M2R_MEM = 2'b10;
  localparam logic [1:0] M2R_IMM = 2'b11;

  // Access size / sign. Any other funct3 is handled as a word access.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

  // Halfwords must sit on even addresses, words (and undefined sizes,
  // which behave as words) on multiples of four. Bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return addr_lo[0];
      default:     return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align -- combinational byte-lane steering for the memory stage.
//   addr_lo    in  2  low address bits of the access
//   funct3     in  3  access size / sign (see rv_pkg)
//   store_data in  N  rs2 value of a store
//   rdata      in  N  word returned by data memory
//   be         out 4  byte enables for the access
//   wdata      out N  store data replicated onto every lane of its size
//   load_data  out N  addressed byte/half/word, sign- or zero-extended
// Halfword accesses only look at addr_lo[1] and word accesses ignore
// addr_lo, so a misaligned access that reaches this block is silently
// rounded down to its natural boundary.
// ---------------------------------------------------------------------------
module lsu_align
  import rv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [1:0]   addr_lo,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] store_data,
  input  logic [N-1:0] rdata,
  output logic [3:0]   be,
  output logic [N-1:0] wdata,
  output logic [N-1:0] load_data
);

  logic [1:0]   offset;   // byte offset actually used for this size
  logic [N-1:0] shifted;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave one unassigned (latch).
  always_comb begin
    offset = 2'b00;
    be     = 4'b1111;
    wdata  = store_data;
    case (funct3)
      F3_B, F3_BU: begin
        offset = addr_lo;
        be     = 4'b0001 << addr_lo;
        wdata  = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        offset = {addr_lo[1], 1'b0};
        be     = 4'b0011 << {addr_lo[1], 1'b0};
        wdata  = {2{store_data[15:0]}};
      end
      default: ;
    endcase

    shifted = rdata >> {offset, 3'b000};

    case (funct3)
      F3_B:    load_data = {{(N-8){shifted[7]}},   shifted[7:0]};
      F3_BU:   load_data = {{(N-8){1'b0}},         shifted[7:0]};
      F3_H:    load_data = {{(N-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {{(N-16){1'b0}},        shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- pipeline MEM stage with a two-state (IDLE/WAIT) handshake to
// data memory and the MEM/WB pipeline register.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   ex_*                EX/MEM register contents (valid, ALU result/address,
//                       store data, funct3, memRead, memWrite, mem2reg,
//                       regWrite, rd, NPC)
//   stall               upstream stages hold while 1
//   dmem_req/we/addr/be/wdata   request to data memory (addr word aligned)
//   dmem_rdata, dmem_ack        response; ack may arrive in the request cycle
//   wb_*                MEM/WB register contents for writeback
//   misalign            only with MEM_MISALIGN_TRAP_EN: one-cycle flag for a
//                       misaligned access, which is dropped as a bubble
//
// In IDLE a memory op is presented combinationally from ex_*. If memory does
// not ack in that cycle the request is registered and the FSM sits in WAIT,
// replaying the registered request until ack. Every stalled cycle writes a
// bubble into MEM/WB. The upstream EX/MEM register is expected to be reset
// together with this stage, so ex_valid is low in the cycle after reset.
// ---------------------------------------------------------------------------
module mem_stage
  import rv_pkg::*;
#(
  parameter int N = 32
) (
`ifdef MEM_MISALIGN_TRAP_EN
  output logic         misalign,
`endif
  input  logic         clk,
  input  logic         rst,
  input  logic         ex_valid,
  input  logic [N-1:0] ex_ALUres,
  input  logic [N-1:0] ex_store_data,
  input  logic [2:0]   ex_funct3,
  input  logic         ex_memRead,
  input  logic         ex_memWrite,
  input  logic [1:0]   ex_mem2reg,
  input  logic         ex_regWrite,
  input  logic [4:0]   ex_rd,
  input  logic [N-1:0] ex_NPC,
  output logic         stall,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [3:0]   dmem_be,
  output logic [N-1:0] dmem_wdata,
  input  logic [N-1:0] dmem_rdata,
  input  logic         dmem_ack,
  output logic         wb_valid,
  output logic [N-1:0] wb_ALUres,
  output logic [N-1:0] wb_MEMread,
  output logic [N-1:0] wb_NPC,
  output logic [1:0]   wb_mem2reg,
  output logic         wb_regWrite,
  output logic [4:0]   wb_rd
);

  mem_state_t state;

  // Request replayed while in WAIT.
  logic         req_we;
  logic [N-1:0] req_addr;
  logic [3:0]   req_be;
  logic [N-1:0] req_wdata;

  // Rest of the instruction held while in WAIT, written to MEM/WB on ack.
  logic [N-1:0] pend_ALUres;
  logic [N-1:0] pend_NPC;
  logic [2:0]   pend_funct3;
  logic         pend_load;
  logic [1:0]   pend_mem2reg;
  logic         pend_regWrite;
  logic [4:0]   pend_rd;

  logic         mem_op;
  logic         mis;      // misaligned op dropped (always 0 without the trap)
  logic         issue;    // IDLE presents a new request this cycle
  logic [1:0]   align_lo;
  logic [2:0]   align_f3;
  logic [3:0]   lane_be;
  logic [N-1:0] lane_wdata;
  logic [N-1:0] load_data;

  // Next MEM/WB contents.
  logic         nx_valid;
  logic [N-1:0] nx_ALUres;
  logic [N-1:0] nx_MEMread;
  logic [N-1:0] nx_NPC;
  logic [1:0]   nx_mem2reg;
  logic         nx_regWrite;
  logic [4:0]   nx_rd;

  assign mem_op = ex_memRead | ex_memWrite;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis      = (state == S_IDLE) & ex_valid & mem_op
                  & is_misaligned(ex_funct3, ex_ALUres[1:0]);
  assign misalign = mis;
`else
  assign mis      = 1'b0;
`endif

  assign issue = (state == S_IDLE) & ex_valid & mem_op & ~mis;

  // In WAIT the lane logic must decode the stalled load, not ex_*.
  assign align_lo = (state == S_WAIT) ? pend_ALUres[1:0] : ex_ALUres[1:0];
  assign align_f3 = (state == S_WAIT) ? pend_funct3      : ex_funct3;

  lsu_align #(.N(N)) u_align (
    .addr_lo    (align_lo),
    .funct3     (align_f3),
    .store_data (ex_store_data),
    .rdata      (dmem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (load_data)
  );

  always_comb begin
    if (state == S_WAIT) begin
      dmem_req   = 1'b1;
      dmem_we    = req_we;
      dmem_addr  = req_addr;
      dmem_be    = req_be;
      dmem_wdata = req_wdata;
    end else begin
      dmem_req   = issue;
      dmem_we    = issue & ex_memWrite;
      dmem_addr  = {ex_ALUres[N-1:2], 2'b00};
      dmem_be    = lane_be;
      dmem_wdata = lane_wdata;
    end
    stall = (issue | (state == S_WAIT)) & ~dmem_ack;
  end

  // Anything that is not a completed instruction leaves MEM/WB all-zero.
  always_comb begin
    nx_valid    = 1'b0;
    nx_ALUres   = '0;
    nx_MEMread  = '0;
    nx_NPC      = '0;
    nx_mem2reg  = 2'b00;
    nx_regWrite = 1'b0;
    nx_rd       = 5'd0;
    if (state == S_IDLE) begin
      if (ex_valid && !stall && !mis) begin
        nx_valid    = 1'b1;
        nx_ALUres   = ex_ALUres;
        nx_MEMread  = ex_memRead ? load_data : '0;
        nx_NPC      = ex_NPC;
        nx_mem2reg  = ex_mem2reg;
        nx_regWrite = ex_regWrite & ~ex_memWrite;
        nx_rd       = ex_rd;
      end
    end else if (dmem_ack) begin
      nx_valid    = 1'b1;
      nx_ALUres   = pend_ALUres;
      nx_MEMread  = pend_load ? load_data : '0;
      nx_NPC      = pend_NPC;
      nx_mem2reg  = pend_mem2reg;
      nx_regWrite = pend_regWrite;
      nx_rd       = pend_rd;
    end
  end

  // FSM and MEM/WB register.
  // NOTE: clocked state uses non-blocking assignments so every register in
  // this block samples values from before the edge, regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wb_valid    <= 1'b0;
      wb_ALUres   <= '0;
      wb_MEMread  <= '0;
      wb_NPC      <= '0;
      wb_mem2reg  <= 2'b00;
      wb_regWrite <= 1'b0;
      wb_rd       <= 5'd0;
    end else begin
      case (state)
        S_IDLE:  if (issue && !dmem_ack) state <= S_WAIT;
        S_WAIT:  if (dmem_ack)           state <= S_IDLE;
        default:                         state <= S_IDLE;
      endcase
      wb_valid    <= nx_valid;
      wb_ALUres   <= nx_ALUres;
      wb_MEMread  <= nx_MEMread;
      wb_NPC      <= nx_NPC;
      wb_mem2reg  <= nx_mem2reg;
      wb_regWrite <= nx_regWrite;
      wb_rd       <= nx_rd;
    end
  end

  // NOTE: the held request is pure datapath and carries no reset; it is only
  // observed while in WAIT, and WAIT is always entered through the load below.
  always_ff @(posedge clk) begin
    if (issue && !dmem_ack) begin
      req_we        <= ex_memWrite;
      req_addr      <= {ex_ALUres[N-1:2], 2'b00};
      req_be        <= lane_be;
      req_wdata     <= lane_wdata;
      pend_ALUres   <= ex_ALUres;
      pend_NPC      <= ex_NPC;
      pend_funct3   <= ex_funct3;
      pend_load     <= ex_memRead;
      pend_mem2reg  <= ex_mem2reg;
      pend_regWrite <= ex_regWrite & ~ex_memWrite;
      pend_rd       <= ex_rd;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- directed self-checking bench for mem_stage.
// Inputs change on the falling edge; combinational outputs are sampled 1 ns
// later, registered outputs 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage;
  import rv_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         ex_valid;
  logic [N-1:0] ex_ALUres;
  logic [N-1:0] ex_store_data;
  logic [2:0]   ex_funct3;
  logic         ex_memRead;
  logic         ex_memWrite;
  logic [1:0]   ex_mem2reg;
  logic         ex_regWrite;
  logic [4:0]   ex_rd;
  logic [N-1:0] ex_NPC;
  logic         stall;
  logic         dmem_req;
  logic         dmem_we;
  logic [N-1:0] dmem_addr;
  logic [3:0]   dmem_be;
  logic [N-1:0] dmem_wdata;
  logic [N-1:0] dmem_rdata;
  logic         dmem_ack;
  logic         wb_valid;
  logic [N-1:0] wb_ALUres;
  logic [N-1:0] wb_MEMread;
  logic [N-1:0] wb_NPC;
  logic [1:0]   wb_mem2reg;
  logic         wb_regWrite;
  logic [4:0]   wb_rd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic         misalign;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_stage #(.N(N)) dut (
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign      (misalign),
`endif
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ALUres     (ex_ALUres),
    .ex_store_data (ex_store_data),
    .ex_funct3     (ex_funct3),
    .ex_memRead    (ex_memRead),
    .ex_memWrite   (ex_memWrite),
    .ex_mem2reg    (ex_mem2reg),
    .ex_regWrite   (ex_regWrite),
    .ex_rd         (ex_rd),
    .ex_NPC        (ex_NPC),
    .stall         (stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .wb_valid      (wb_valid),
    .wb_ALUres     (wb_ALUres),
    .wb_MEMread    (wb_MEMread),
    .wb_NPC        (wb_NPC),
    .wb_mem2reg    (wb_mem2reg),
    .wb_regWrite   (wb_regWrite),
    .wb_rd         (wb_rd)
  );

  task automatic clear_ex();
    ex_valid      = 1'b0;
    ex_ALUres     = '0;
    ex_store_data = '0;
    ex_funct3     = 3'b000;
    ex_memRead    = 1'b0;
    ex_memWrite   = 1'b0;
    ex_mem2reg    = 2'b00;
    ex_regWrite   = 1'b0;
    ex_rd         = 5'd0;
    ex_NPC        = '0;
    dmem_ack      = 1'b0;
    dmem_rdata    = '0;
  endtask

  // Stimulus only: present one memory op on ex_* (call after a falling edge).
  task automatic drive_mem(input logic is_store, input logic [2:0] f3,
                           input logic [N-1:0] addr, input logic [N-1:0] sdata,
                           input logic [4:0] rd);
    ex_valid      = 1'b1;
    ex_ALUres     = addr;
    ex_store_data = sdata;
    ex_funct3     = f3;
    ex_memRead    = ~is_store;
    ex_memWrite   = is_store;
    ex_mem2reg    = M2R_MEM;
    ex_regWrite   = 1'b1;
    ex_rd         = rd;
    ex_NPC        = addr + 32'h1000;
  endtask

  task automatic test_reset();
    clear_ex();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0)
      $display("FAIL reset_req_stall: req=%b stall=%b, want 0 0", dmem_req, stall);
    else n_pass++;
    n_checks++;
    if ({wb_valid, wb_regWrite, wb_mem2reg, wb_rd} !== 9'd0 ||
        wb_ALUres !== '0 || wb_MEMread !== '0 || wb_NPC !== '0)
      $display("FAIL reset_wb: valid=%b rw=%b alu=%h mem=%h npc=%h, want all 0",
               wb_valid, wb_regWrite, wb_ALUres, wb_MEMread, wb_NPC);
    else n_pass++;
  endtask

  task automatic test_alu();
    @(negedge clk);
    clear_ex();
    ex_valid = 1'b1; ex_ALUres = 32'h1234; ex_mem2reg = M2R_ALU;
    ex_regWrite = 1'b1; ex_rd = 5'd5; ex_NPC = 32'h104;
    #1;
    n_checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL alu_no_req: stall=%b req=%b, want 0 0", stall, dmem_req);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (wb_valid !== 1'b1 || wb_ALUres !== 32'h1234 || wb_mem2reg !== M2R_ALU ||
        wb_regWrite !== 1'b1 || wb_rd !== 5'd5 || wb_NPC !== 32'h104 || wb_MEMread !== '0)
      $display("FAIL alu_capture: valid=%b alu=%h m2r=%b rw=%b rd=%0d npc=%h mem=%h, want 1 1234 01 1 5 104 0",
               wb_valid, wb_ALUres, wb_mem2reg, wb_regWrite, wb_rd, wb_NPC, wb_MEMread);
    else n_pass++;
    @(negedge clk);
    clear_ex();
    @(posedge clk); #1;
    n_checks++;
    if (wb_valid !== 1'b0 || wb_regWrite !== 1'b0)
      $display("FAIL alu_idle_bubble: valid=%b rw=%b, want 0 0", wb_valid, wb_regWrite);
    else n_pass++;
  endtask

  // Loads acked in the request cycle: {funct3, addr, rdata, be, expected}.
  task automatic test_loads();
    logic [2:0]   f3  [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0]  adr [4] = '{32'h103, 32'h101, 32'h102, 32'h000};
    logic [31:0]  rd_w[4] = '{32'h80FF_FF12, 32'h1234_F678, 32'h8001_0000, 32'h0000_9ABC};
    logic [3:0]   be  [4] = '{4'b1000, 4'b0010, 4'b1100, 4'b0011};
    logic [31:0]  exp [4] = '{32'hFFFF_FF80, 32'h0000_00F6, 32'hFFFF_8001, 32'h0000_9ABC};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_ex();
      drive_mem(1'b0, f3[i], adr[i], '0, 5'd7);
      dmem_rdata = rd_w[i];
      dmem_ack   = 1'b1;
      #1;
      n_checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || stall !== 1'b0 ||
          dmem_addr !== {adr[i][31:2], 2'b00} || dmem_be !== be[i])
        $display("FAIL load%0d_req: req=%b we=%b stall=%b addr=%h be=%b, want 1 0 0 %h %b",
                 i, dmem_req, dmem_we, stall, dmem_addr, dmem_be,
                 {adr[i][31:2], 2'b00}, be[i]);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (wb_valid !== 1'b1 || wb_MEMread !== exp[i] || wb_regWrite !== 1'b1 ||
          wb_rd !== 5'd7 || stall !== 1'b0)
        $display("FAIL load%0d_wb: valid=%b mem=%h rw=%b rd=%0d stall=%b, want 1 %h 1 7 0",
                 i, wb_valid, wb_MEMread, wb_regWrite, wb_rd, stall, exp[i]);
      else n_pass++;
    end
    @(negedge clk);
    clear_ex();
  endtask

  // Stores acked in the request cycle: {funct3, addr, data, be, wdata}.
  task automatic test_stores();
    logic [2:0]  f3  [3] = '{F3_H, F3_B, F3_W};
    logic [31:0] adr [3] = '{32'h202, 32'h001, 32'h010};
    logic [31:0] sd  [3] = '{32'h0000_ABCD, 32'h1234_5655, 32'hDEAD_BEEF};
    logic [3:0]  be  [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] wd  [3] = '{32'hABCD_ABCD, 32'h5555_5555, 32'hDEAD_BEEF};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clear_ex();
      drive_mem(1'b1, f3[i], adr[i], sd[i], 5'd9);
      dmem_ack = 1'b1;
      #1;
      n_checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || stall !== 1'b0 ||
          dmem_be !== be[i] || dmem_wdata !== wd[i] || dmem_addr !== {adr[i][31:2], 2'b00})
        $display("FAIL store%0d_req: req=%b we=%b stall=%b be=%b wdata=%h addr=%h, want 1 1 0 %b %h %h",
                 i, dmem_req, dmem_we, stall, dmem_be, dmem_wdata, dmem_addr,
                 be[i], wd[i], {adr[i][31:2], 2'b00});
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (wb_valid !== 1'b1 || wb_regWrite !== 1'b0 || wb_MEMread !== '0)
        $display("FAIL store%0d_wb: valid=%b rw=%b mem=%h, want 1 0 0",
                 i, wb_valid, wb_regWrite, wb_MEMread);
      else n_pass++;
    end
    @(negedge clk);
    clear_ex();
  endtask

  // LW whose ack arrives in the fourth cycle of the request.
  task automatic test_wait_load();
    @(negedge clk);
    clear_ex();
    drive_mem(1'b0, F3_W, 32'h300, '0, 5'd12);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (stall !== 1'b1 || dmem_req !== 1'b1 || dmem_addr !== 32'h300 || dmem_we !== 1'b0)
        $display("FAIL wait%0d_req: stall=%b req=%b addr=%h we=%b, want 1 1 300 0",
                 i, stall, dmem_req, dmem_addr, dmem_we);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (wb_valid !== 1'b0 || wb_regWrite !== 1'b0)
        $display("FAIL wait%0d_bubble: valid=%b rw=%b, want 0 0", i, wb_valid, wb_regWrite);
      else n_pass++;
      @(negedge clk);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    #1;
    n_checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b1 || dmem_addr !== 32'h300)
      $display("FAIL wait_ack_req: stall=%b req=%b addr=%h, want 0 1 300",
               stall, dmem_req, dmem_addr);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (wb_valid !== 1'b1 || wb_MEMread !== 32'hCAFE_F00D || wb_rd !== 5'd12 ||
        wb_regWrite !== 1'b1 || wb_ALUres !== 32'h300)
      $display("FAIL wait_capture: valid=%b mem=%h rd=%0d rw=%b alu=%h, want 1 cafef00d 12 1 300",
               wb_valid, wb_MEMread, wb_rd, wb_regWrite, wb_ALUres);
    else n_pass++;
    @(negedge clk);
    clear_ex();
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0)
      $display("FAIL wait_back_idle: req=%b stall=%b, want 0 0", dmem_req, stall);
    else n_pass++;
  endtask

  // Reset in the second WAIT cycle; a late ack must be ignored.
  task automatic test_reset_in_wait();
    @(negedge clk);
    clear_ex();
    drive_mem(1'b0, F3_W, 32'h400, '0, 5'd3);
    @(negedge clk);          // first WAIT cycle
    @(negedge clk);          // second WAIT cycle
    #1;
    n_checks++;
    if (dmem_req !== 1'b1 || stall !== 1'b1)
      $display("FAIL rstwait_pre: req=%b stall=%b, want 1 1", dmem_req, stall);
    else n_pass++;
    rst = 1'b1;
    ex_valid = 1'b0;         // upstream is reset alongside
    @(negedge clk);
    rst = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5A5A_5A5A;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0)
      $display("FAIL rstwait_after: req=%b stall=%b wb_valid=%b, want 0 0 0",
               dmem_req, stall, wb_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (wb_valid !== 1'b0 || wb_MEMread !== '0 || wb_regWrite !== 1'b0)
      $display("FAIL rstwait_late_ack: valid=%b mem=%h rw=%b, want 0 0 0",
               wb_valid, wb_MEMread, wb_regWrite);
    else n_pass++;
    @(negedge clk);
    clear_ex();
  endtask

  task automatic test_misalign();
    @(negedge clk);
    clear_ex();
    drive_mem(1'b0, F3_W, 32'h101, '0, 5'd4);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1122_3344;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    n_checks++;
    if (misalign !== 1'b1 || dmem_req !== 1'b0 || stall !== 1'b0)
      $display("FAIL mis_lw: misalign=%b req=%b stall=%b, want 1 0 0", misalign, dmem_req, stall);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (wb_valid !== 1'b0 || wb_regWrite !== 1'b0)
      $display("FAIL mis_bubble: valid=%b rw=%b, want 0 0", wb_valid, wb_regWrite);
    else n_pass++;
`else
    n_checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'b1111 || stall !== 1'b0)
      $display("FAIL unaligned_lw: req=%b addr=%h be=%b stall=%b, want 1 100 1111 0",
               dmem_req, dmem_addr, dmem_be, stall);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (wb_valid !== 1'b1 || wb_MEMread !== 32'h1122_3344)
      $display("FAIL unaligned_lw_wb: valid=%b mem=%h, want 1 11223344", wb_valid, wb_MEMread);
    else n_pass++;
    @(negedge clk);
    clear_ex();
    drive_mem(1'b0, F3_HU, 32'h103, '0, 5'd4);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h7FFF_0000;
    #1;
    n_checks++;
    if (dmem_be !== 4'b1100 || dmem_addr !== 32'h100)
      $display("FAIL unaligned_lhu_req: be=%b addr=%h, want 1100 100", dmem_be, dmem_addr);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (wb_MEMread !== 32'h0000_7FFF)
      $display("FAIL unaligned_lhu_wb: mem=%h, want 00007fff", wb_MEMread);
    else n_pass++;
`endif
    @(negedge clk);
    clear_ex();
  endtask

  initial begin
    rst = 1'b1;
    clear_ex();
    test_reset();
    test_alu();
    test_loads();
    test_stores();
    test_wait_load();
    test_reset_in_wait();
    test_misalign();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
